// File: rtl/memory_cycle_pkg.sv
// Shared encodings for the memory stage: result-source select, RV32I load/store
// size codes and the access FSM states.
package memory_cycle_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/memory_cycle_load_extend.sv
// Selects the addressed byte/halfword of a read word and sign/zero-extends it.
module load_extend
    import memory_cycle_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        shifted = rdata >> {addr, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = addr[1] ? rdata[31:16] : rdata[15:0];
        // Illegal size codes fall through to the full word.
        case (funct3)
            F3_LB:   data = {{24{byte_v[7]}}, byte_v};
            F3_LBU:  data = {24'h0, byte_v};
            F3_LH:   data = {{16{half_v[15]}}, half_v};
            F3_LHU:  data = {16'h0, half_v};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/memory_cycle.sv
// Memory pipeline stage: issues the data-memory access, stalls while the bus is
// busy, aborts on timeout and feeds the M/W pipeline register.
module memory_cycle
    import memory_cycle_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  Funct3M,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] ALU_ResultM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] PCPlus4W,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          misalign_q, misalign_d;
    logic          buserr_q, buserr_d;
    logic          regwrite_q, regwrite_d;
    logic [1:0]    resultsrc_q, resultsrc_d;
    logic [4:0]    rd_q, rd_d;
    logic [31:0]   pc4_q, pc4_d;
    logic [31:0]   alu_q, alu_d;
    logic [31:0]   rdata_q, rdata_d;

    logic        is_store, access, is_byte, is_half, aligned;
    logic        req, stall, complete;
    logic [31:0] ext_data;

    load_extend u_load_extend (
        .addr   (ALU_ResultM[1:0]),
        .funct3 (Funct3M),
        .rdata  (dmem_rdata),
        .data   (ext_data)
    );

    // Unsigned size codes exist only for loads; a store with one is illegal and
    // therefore handled as a word.
    always_comb begin
        is_store = MemWriteM;
        access   = MemWriteM || (ResultSrcM == RES_MEM);
        is_byte  = (Funct3M == F3_LB) || (!is_store && Funct3M == F3_LBU);
        is_half  = (Funct3M == F3_LH) || (!is_store && Funct3M == F3_LHU);
        if (is_byte)      aligned = 1'b1;
        else if (is_half) aligned = !ALU_ResultM[0];
        else              aligned = (ALU_ResultM[1:0] == 2'b00);
    end

    always_comb begin
        dmem_addr = {ALU_ResultM[31:2], 2'b00};
        if (!is_store) begin
            dmem_be    = 4'b1111;
            dmem_wdata = WriteDataM;
        end else if (is_byte) begin
            dmem_be    = 4'b0001 << ALU_ResultM[1:0];
            dmem_wdata = {4{WriteDataM[7:0]}};
        end else if (is_half) begin
            dmem_be    = 4'b0011 << {ALU_ResultM[1], 1'b0};
            dmem_wdata = {2{WriteDataM[15:0]}};
        end else begin
            dmem_be    = 4'b1111;
            dmem_wdata = WriteDataM;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req        = 1'b0;
        stall      = 1'b0;
        complete   = 1'b0;
        misalign_d = 1'b0;
        buserr_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!access) begin
                    complete = 1'b1;
                end else if (!aligned) begin
                    misalign_d = 1'b1;
                end else begin
                    req = 1'b1;
                    if (dmem_ready) begin
                        complete = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            ST_WAIT: begin
                req = 1'b1;
                // Ready beats the timeout when both land in the same cycle.
                if (dmem_ready) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    buserr_d = 1'b1;
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Anything that is not a completion (stall, misalign, abort) is a zero bubble.
    always_comb begin
        regwrite_d  = 1'b0;
        resultsrc_d = 2'b00;
        rd_d        = 5'd0;
        pc4_d       = 32'h0;
        alu_d       = 32'h0;
        rdata_d     = 32'h0;
        if (complete) begin
            regwrite_d  = RegWriteM;
            resultsrc_d = ResultSrcM;
            rd_d        = RD_M;
            pc4_d       = PCPlus4M;
            alu_d       = ALU_ResultM;
            rdata_d     = ext_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            misalign_q  <= 1'b0;
            buserr_q    <= 1'b0;
            regwrite_q  <= 1'b0;
            resultsrc_q <= 2'b00;
            rd_q        <= 5'd0;
            pc4_q       <= 32'h0;
            alu_q       <= 32'h0;
            rdata_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            misalign_q  <= misalign_d;
            buserr_q    <= buserr_d;
            regwrite_q  <= regwrite_d;
            resultsrc_q <= resultsrc_d;
            rd_q        <= rd_d;
            pc4_q       <= pc4_d;
            alu_q       <= alu_d;
            rdata_q     <= rdata_d;
        end
    end

    assign dmem_req    = req && !reset;
    assign dmem_we     = dmem_req && MemWriteM;
    assign StallM      = stall;
    assign MisalignM   = misalign_q;
    assign BusErrM     = buserr_q;
    assign RegWriteW   = regwrite_q;
    assign ResultSrcW  = resultsrc_q;
    assign RD_W        = rd_q;
    assign PCPlus4W    = pc4_q;
    assign ALU_ResultW = alu_q;
    assign ReadDataW   = rdata_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle: loads, stores, wait states, misalignment,
// bus timeout and reset during an outstanding access.
module tb_memory_cycle;

    logic        clock = 1'b0;
    logic        reset;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        StallM, MisalignM, BusErrM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

    int checks = 0;
    int errors = 0;

    memory_cycle #(.TIMEOUT(4)) dut (
        .clock(clock), .reset(reset),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .Funct3M(Funct3M), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
        .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RD_W(RD_W),
        .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic mw, input logic [1:0] rs, input logic [2:0] f3,
                         input logic rw, input logic [31:0] addr, input logic [31:0] wd);
        MemWriteM   = mw;
        ResultSrcM  = rs;
        Funct3M     = f3;
        RegWriteM   = rw;
        ALU_ResultM = addr;
        WriteDataM  = wd;
        RD_M        = 5'd7;
        PCPlus4M    = 32'h0000_1004;
    endtask

    task automatic nop();
        drive(1'b0, 2'b00, 3'b000, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        dmem_ready = 1'b1;
        dmem_rdata = 32'h0;
        drive(1'b0, 2'b01, 3'b010, 1'b1, 32'h100, 32'h0);
        #12;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", dmem_req); end
        checks++; if ({RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW} !== '0) begin errors++; $display("FAIL reset_w got %b %h %h %h", RegWriteW, RD_W, ALU_ResultW, ReadDataW); end
        checks++; if ({MisalignM, BusErrM} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b%b exp 00", MisalignM, BusErrM); end
        @(negedge clock);
        reset = 1'b0;
        nop();
        step();
    endtask

    task automatic test_lw_ready();
        dmem_ready = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        drive(1'b0, 2'b01, 3'b010, 1'b1, 32'h100, 32'h0);
        @(negedge clock);
        checks++; if ({dmem_req, dmem_we, StallM} !== 3'b100) begin errors++; $display("FAIL lw_ctrl got req/we/stall %b%b%b exp 100", dmem_req, dmem_we, StallM); end
        checks++; if (dmem_addr !== 32'h100 || dmem_be !== 4'b1111) begin errors++; $display("FAIL lw_addr got %h be %b exp 00000100 be 1111", dmem_addr, dmem_be); end
        step();
        checks++; if (ReadDataW !== 32'hDEAD_BEEF || RegWriteW !== 1'b1 || RD_W !== 5'd7) begin errors++; $display("FAIL lw_w got %h rw %b rd %0d exp deadbeef 1 7", ReadDataW, RegWriteW, RD_W); end
    endtask

    task automatic test_lb_lbu();
        dmem_ready = 1'b1;
        dmem_rdata = 32'h80FF_FFFF;
        drive(1'b0, 2'b01, 3'b000, 1'b1, 32'h103, 32'h0);
        step();
        checks++; if (ReadDataW !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb got %h exp ffffff80", ReadDataW); end
        drive(1'b0, 2'b01, 3'b100, 1'b1, 32'h103, 32'h0);
        step();
        checks++; if (ReadDataW !== 32'h0000_0080) begin errors++; $display("FAIL lbu got %h exp 00000080", ReadDataW); end
        dmem_rdata = 32'h80FF_1234;
        drive(1'b0, 2'b01, 3'b101, 1'b1, 32'h102, 32'h0);
        step();
        checks++; if (ReadDataW !== 32'h0000_80FF) begin errors++; $display("FAIL lhu got %h exp 000080ff", ReadDataW); end
        drive(1'b0, 2'b01, 3'b001, 1'b1, 32'h102, 32'h0);
        step();
        checks++; if (ReadDataW !== 32'hFFFF_80FF) begin errors++; $display("FAIL lh got %h exp ffff80ff", ReadDataW); end
    endtask

    task automatic test_stores();
        dmem_ready = 1'b1;
        drive(1'b1, 2'b00, 3'b001, 1'b0, 32'h202, 32'h1234_ABCD);
        @(negedge clock);
        checks++; if (dmem_be !== 4'b1100 || dmem_wdata !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_lane got be %b %h exp 1100 abcdabcd", dmem_be, dmem_wdata); end
        checks++; if ({dmem_req, dmem_we, StallM} !== 3'b110 || dmem_addr !== 32'h200) begin errors++; $display("FAIL sh_ctrl got %b%b%b %h exp 110 00000200", dmem_req, dmem_we, StallM, dmem_addr); end
        step();
        drive(1'b1, 2'b00, 3'b000, 1'b0, 32'h201, 32'h0000_00EF);
        @(negedge clock);
        checks++; if (dmem_be !== 4'b0010 || dmem_wdata !== 32'hEFEF_EFEF) begin errors++; $display("FAIL sb_lane got be %b %h exp 0010 efefefef", dmem_be, dmem_wdata); end
        step();
        drive(1'b1, 2'b00, 3'b010, 1'b0, 32'h204, 32'h5566_7788);
        @(negedge clock);
        checks++; if (dmem_be !== 4'b1111 || dmem_wdata !== 32'h5566_7788) begin errors++; $display("FAIL sw_lane got be %b %h exp 1111 55667788", dmem_be, dmem_wdata); end
        step();
    endtask

    task automatic test_alu_pass();
        dmem_ready = 1'b0;
        drive(1'b0, 2'b00, 3'b010, 1'b1, 32'h55, 32'h0);
        @(negedge clock);
        checks++; if (dmem_req !== 1'b0 || StallM !== 1'b0) begin errors++; $display("FAIL alu_noreq got req %b stall %b exp 0 0", dmem_req, StallM); end
        step();
        checks++; if (RegWriteW !== 1'b1 || ALU_ResultW !== 32'h55 || PCPlus4W !== 32'h1004 || ResultSrcW !== 2'b00) begin errors++; $display("FAIL alu_w got rw %b alu %h pc4 %h rs %b", RegWriteW, ALU_ResultW, PCPlus4W, ResultSrcW); end
    endtask

    task automatic test_wait();
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        drive(1'b0, 2'b01, 3'b010, 1'b1, 32'h300, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++; if (StallM !== 1'b1 || dmem_req !== 1'b1) begin errors++; $display("FAIL wait_stall%0d got stall %b req %b exp 1 1", i, StallM, dmem_req); end
            step();
            checks++; if (RegWriteW !== 1'b0) begin errors++; $display("FAIL wait_bubble%0d got rw %b exp 0", i, RegWriteW); end
        end
        dmem_ready = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        @(negedge clock);
        checks++; if (StallM !== 1'b0 || dmem_req !== 1'b1) begin errors++; $display("FAIL wait_done got stall %b req %b exp 0 1", StallM, dmem_req); end
        step();
        checks++; if (ReadDataW !== 32'hCAFE_F00D || RegWriteW !== 1'b1) begin errors++; $display("FAIL wait_data got %h rw %b exp cafef00d 1", ReadDataW, RegWriteW); end
        nop();
        @(negedge clock);
        checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL wait_idle got stall %b exp 0", StallM); end
        step();
    endtask

    task automatic test_misalign();
        dmem_ready = 1'b1;
        drive(1'b0, 2'b01, 3'b001, 1'b1, 32'h101, 32'h0);
        @(negedge clock);
        checks++; if (dmem_req !== 1'b0 || StallM !== 1'b0) begin errors++; $display("FAIL mis_req got req %b stall %b exp 0 0", dmem_req, StallM); end
        step();
        checks++; if (MisalignM !== 1'b1 || RegWriteW !== 1'b0) begin errors++; $display("FAIL mis_pulse got mis %b rw %b exp 1 0", MisalignM, RegWriteW); end
        drive(1'b0, 2'b00, 3'b000, 1'b1, 32'h9, 32'h0);
        step();
        checks++; if (MisalignM !== 1'b0 || RegWriteW !== 1'b1) begin errors++; $display("FAIL mis_clear got mis %b rw %b exp 0 1", MisalignM, RegWriteW); end
        drive(1'b1, 2'b00, 3'b010, 1'b0, 32'h102, 32'h0);
        step();
        checks++; if (MisalignM !== 1'b1) begin errors++; $display("FAIL mis_sw got mis %b exp 1", MisalignM); end
    endtask

    task automatic test_timeout();
        dmem_ready = 1'b0;
        drive(1'b0, 2'b01, 3'b010, 1'b1, 32'h400, 32'h0);
        // One IDLE stall cycle plus TIMEOUT=4 waiting cycles, then the abort cycle.
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++; if (StallM !== 1'b1) begin errors++; $display("FAIL to_stall%0d got %b exp 1", i, StallM); end
            step();
            checks++; if (BusErrM !== 1'b0) begin errors++; $display("FAIL to_early%0d got buserr %b exp 0", i, BusErrM); end
        end
        @(negedge clock);
        checks++; if (StallM !== 1'b0) begin errors++; $display("FAIL to_drop got stall %b exp 0", StallM); end
        step();
        checks++; if (BusErrM !== 1'b1 || RegWriteW !== 1'b0) begin errors++; $display("FAIL to_pulse got buserr %b rw %b exp 1 0", BusErrM, RegWriteW); end
        drive(1'b0, 2'b00, 3'b000, 1'b1, 32'h77, 32'h0);
        step();
        checks++; if (BusErrM !== 1'b0 || RegWriteW !== 1'b1 || ALU_ResultW !== 32'h77) begin errors++; $display("FAIL to_after got buserr %b rw %b alu %h exp 0 1 77", BusErrM, RegWriteW, ALU_ResultW); end
    endtask

    task automatic test_reset_in_wait();
        dmem_ready = 1'b0;
        drive(1'b0, 2'b01, 3'b010, 1'b1, 32'h500, 32'h0);
        step();
        checks++; if (dmem_req !== 1'b1 || StallM !== 1'b1) begin errors++; $display("FAIL rw_wait got req %b stall %b exp 1 1", dmem_req, StallM); end
        reset = 1'b1;
        #1;
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rw_req got %b exp 0", dmem_req); end
        checks++; if ({RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW} !== '0) begin errors++; $display("FAIL rw_w got rw %b rd %0d alu %h rdata %h exp zeros", RegWriteW, RD_W, ALU_ResultW, ReadDataW); end
        @(negedge clock);
        reset = 1'b0;
        dmem_ready = 1'b1;
        dmem_rdata = 32'h1122_3344;
        #1;
        checks++; if (StallM !== 1'b0 || dmem_req !== 1'b1) begin errors++; $display("FAIL rw_idle got stall %b req %b exp 0 1", StallM, dmem_req); end
        step();
        checks++; if (ReadDataW !== 32'h1122_3344 || RegWriteW !== 1'b1) begin errors++; $display("FAIL rw_data got %h rw %b exp 11223344 1", ReadDataW, RegWriteW); end
        nop();
        step();
    endtask

    initial begin
        test_reset();
        test_lw_ready();
        test_lb_lbu();
        test_stores();
        test_alu_pass();
        test_wait();
        test_misalign();
        test_timeout();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_cycle.md
MEMORY_CYCLE -- requirements
Module: memory_cycle

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255: the maximum number of WAIT cycles before a bus-error abort.
REQ-002 The block SHALL have the following ports; reset is asynchronous and active-high, and clock is the single clock:
- clock  in  1  single clock
- reset  in  1  asynchronous reset, active-high
- RegWriteM  in  1  register write enable from the E/M register
- MemWriteM  in  1  store
- ResultSrcM  in  2  00 ALU, 01 load, 10 PC+4
- Funct3M  in  3  access size/sign (RV32I load/store encoding)
- RD_M  in  5  destination register
- PCPlus4M  in  32  return address
- WriteDataM  in  32  store data, already forwarded
- ALU_ResultM  in  32  effective address or ALU result
- dmem_req  out  1  memory request valid
- dmem_we  out  1  write strobe
- dmem_addr  out  32  word address {ALU_ResultM[31:2], 2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ready  in  1  request accepted or completed; dmem_rdata valid
- dmem_rdata  in  32  read word
- StallM  out  1  upstream stages SHALL hold F/D/E and M inputs stable while this is high
- MisalignM  out  1  one-cycle registered pulse on a misaligned access
- BusErrM  out  1  one-cycle registered pulse on a timeout
- RegWriteW, ResultSrcW[1:0], RD_W[4:0], PCPlus4W[31:0], ALU_ResultW[31:0], ReadDataW[31:0]  out  M/W register outputs

Function
REQ-003 An access exists when MemWriteM=1 or ResultSrcM=01; any other instruction SHALL pass straight into the M/W register with 1-cycle latency and no request.
REQ-004 The FSM SHALL have two states, IDLE and WAIT.
REQ-005 In IDLE with an aligned access, dmem_req SHALL be 1 combinationally. If dmem_ready=1 in that cycle, the access completes with no stall; otherwise the FSM SHALL go to WAIT.
REQ-006 In WAIT, dmem_req and StallM SHALL both be 1, with request fields driven from the held M inputs. On dmem_ready=1 the access SHALL complete, StallM SHALL drop in that same cycle, and the FSM SHALL return to IDLE at the next edge.
REQ-007 StallM SHALL equal (IDLE and access and aligned and !dmem_ready) or (WAIT and !dmem_ready).
REQ-008 While StallM=1, the M/W register SHALL load a bubble: RegWriteW=0, with other fields don't-care but deterministic.
REQ-009 Alignment SHALL be checked as follows: halfword requires ALU_ResultM[0]=0; word requires ALU_ResultM[1:0]=00.
- On a misaligned access: no request, no stall, a bubble is written to W, and MisalignM=1 for the next cycle.
REQ-010 Store byte enables and data SHALL be:
- SB: be = 0001 shifted left by addr[1:0]; wdata = byte replicated x4.
- SH: be = 0011 shifted left by addr[1]*2; wdata = halfword replicated x2.
- SW: be = 1111.
- Loads: be = 1111, dmem_we = 0.
REQ-011 Load data SHALL be extracted from dmem_rdata by addr[1:0]:
- LB/LH: sign-extended.
- LBU/LHU: zero-extended.
- LW: passed unmodified.
- The result SHALL be latched into ReadDataW at completion.
REQ-012 A wait counter SHALL clear on entry to WAIT and increment each WAIT cycle. When it reaches TIMEOUT with dmem_ready=0, the block SHALL abort: return to IDLE, write a bubble to W, pulse BusErrM, and drop StallM.
REQ-013 If dmem_ready and the timeout occur in the same cycle, dmem_ready SHALL win (normal completion).
REQ-014 Funct3M values outside the legal load/store set SHALL be treated as word accesses.

Reset
REQ-015 Asserting reset SHALL immediately force the following, including mid-WAIT, where the outstanding access is dropped:
- FSM = IDLE, counter = 0;
- all W outputs = 0;
- MisalignM = BusErrM = 0;
- dmem_req = 0 while reset is high.
REQ-016 After reset deasserts, the first clock edge SHALL behave as IDLE.

Structure
REQ-017 The following SHALL live in a shared package: the ResultSrc encodings (ALU/MEM/PC4), the Funct3 size codes (LB, LH, LW, LBU, LHU, SB, SH, SW), and the FSM state enum.
REQ-018 One sub-module, load_extend (addr[1:0], Funct3, rdata -> extended data), SHALL be used; store lane logic SHALL be inline.

Verification
REQ-019 LW at 0x100 with dmem_ready tied to 1, rdata=0xDEADBEEF -> no stall; next cycle ReadDataW=0xDEADBEEF, RegWriteW=1.
REQ-020 LB at 0x103, rdata=0x80FFFFFF -> ReadDataW=0xFFFFFF80; LBU gives 0x00000080.
REQ-021 SH at 0x202, WriteDataM=0x1234ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1.
REQ-022 LW with dmem_ready low for 3 cycles -> StallM=1 for exactly 3 cycles, 3 bubbles in W, data latched on the 4th edge.
REQ-023 LH at 0x101 -> dmem_req=0, MisalignM pulses once, RegWriteW=0; with TIMEOUT=4 and ready never asserted -> BusErrM pulses and StallM drops.
REQ-024 reset asserted in WAIT -> dmem_req=0 and all W outputs 0 immediately; the next access starts from IDLE.
